// File: rtl/wide_to_narrow_if.sv
// Purpose: valid/ready stream bundle (data, per-byte keep, frame last) for wide_to_narrow.
// Latency: none, wires only.
// Backpressure: a transfer happens on a cycle where val & rdy are both high.
// Ports (signals): val/data/keep/last flow master->slave; rdy flows slave->master.
interface wide_to_narrow_if #(
    parameter int DATA_W = 64,
    parameter int KEEP_W = DATA_W / 8
);
    logic              val;
    logic [DATA_W-1:0] data;
    logic [KEEP_W-1:0] keep;
    logic              last;
    logic              rdy;

    modport master (output val, output data, output keep, output last, input rdy);
    modport slave  (input val, input data, input keep, input last, output rdy);
endinterface

// File: rtl/wide_to_narrow.sv
// Purpose: serialise one wide line of IN_DATA_ELS elements into narrow beats, highest element first.
// Latency: first beat one cycle after the line is accepted; one beat per cycle sustained.
// Backpressure: dst rdy low freezes every output and state; src rdy only rises on the final beat.
// Ports: clk, rst (sync, active high); src = wide line slave side; dst = narrow beat master side.
//        On a frame's last line, emission stops after the last element whose successor keep is zero.
module wide_to_narrow #(
    parameter int OUT_DATA_W  = 64,
    parameter int OUT_KEEP_W  = OUT_DATA_W / 8,
    parameter int IN_DATA_ELS = 4
) (
    input  logic              clk,
    input  logic              rst,
    wide_to_narrow_if.slave   src,
    wide_to_narrow_if.master  dst
);
    localparam int IDX_W = (IN_DATA_ELS > 1) ? $clog2(IN_DATA_ELS) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(IN_DATA_ELS - 1);

    typedef enum logic {
        READY  = 1'b0,
        OUTPUT = 1'b1
    } state_t;

    state_t                             state, state_nxt;
    logic [IN_DATA_ELS*OUT_DATA_W-1:0]  line_data;
    logic [IN_DATA_ELS*OUT_KEEP_W-1:0]  line_keep;
    logic                               line_last;
    logic [IDX_W-1:0]                   idx;
    logic [IDX_W-1:0]                   idx_m1;

    logic                               load;
    logic                               dec;
    logic                               src_rdy_c;
    logic                               dst_val_c;
    logic                               end_line;
    logic [OUT_KEEP_W-1:0]              next_keep;

    // idx_m1 is only meaningful when idx > 0; clamp so the slice stays in range.
    assign idx_m1    = (idx == '0) ? '0 : idx - 1'b1;
    assign next_keep = line_keep[int'(idx_m1)*OUT_KEEP_W +: OUT_KEEP_W];

    // The line ends at element 0, or early on a frame's last line once the next element is empty.
    // The top element is always emitted because the test looks one element ahead.
    assign end_line  = (idx == '0) || (line_last && (next_keep == '0));

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        dec       = 1'b0;
        src_rdy_c = 1'b0;
        dst_val_c = 1'b0;
        case (state)
            READY: begin
                src_rdy_c = 1'b1;
                if (src.val) begin
                    load      = 1'b1;
                    state_nxt = OUTPUT;
                end
            end
            OUTPUT: begin
                dst_val_c = 1'b1;
                if (dst.rdy) begin
                    if (end_line) begin
                        // Accept the next line on the final beat so lines chain without a bubble.
                        src_rdy_c = 1'b1;
                        if (src.val) begin
                            load = 1'b1;
                        end else begin
                            state_nxt = READY;
                        end
                    end else begin
                        dec = 1'b1;
                    end
                end
            end
            default: state_nxt = READY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= READY;
            idx       <= IDX_TOP;
            line_keep <= '0;
            line_last <= 1'b0;
        end else begin
            state <= state_nxt;
            if (load) begin
                idx       <= IDX_TOP;
                line_keep <= src.keep;
                line_last <= src.last;
            end else if (dec) begin
                idx <= idx - 1'b1;
            end
        end
    end

    // Line data carries no control meaning, so it is left out of reset.
    always_ff @(posedge clk) begin
        if (load) begin
            line_data <= src.data;
        end
    end

    assign src.rdy  = src_rdy_c;
    assign dst.val  = dst_val_c;
    assign dst.data = line_data[int'(idx)*OUT_DATA_W +: OUT_DATA_W];
    assign dst.keep = line_keep[int'(idx)*OUT_KEEP_W +: OUT_KEEP_W];
    assign dst.last = (state == OUTPUT) && line_last && end_line;
endmodule

// File: tb/tb_wide_to_narrow.sv
module tb_wide_to_narrow;
    localparam int DW  = 64;
    localparam int KW  = 8;
    localparam int ELS = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wide_to_narrow_if #(.DATA_W(ELS*DW), .KEEP_W(ELS*KW)) src_if ();
    wide_to_narrow_if #(.DATA_W(DW),     .KEEP_W(KW))     dst_if ();

    wide_to_narrow #(
        .OUT_DATA_W  (DW),
        .OUT_KEEP_W  (KW),
        .IN_DATA_ELS (ELS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .src (src_if.slave),
        .dst (dst_if.master)
    );

    int checks = 0;
    int errors = 0;

    localparam logic [63:0] EA = 64'hA0A0_0000_0000_0003;
    localparam logic [63:0] EB = 64'hB0B0_0000_0000_0002;
    localparam logic [63:0] EC = 64'hC0C0_0000_0000_0001;
    localparam logic [63:0] ED = 64'hD0D0_0000_0000_0000;
    localparam logic [63:0] EE = 64'hE0E0_1111_0000_0003;
    localparam logic [63:0] EF = 64'hF0F0_1111_0000_0002;
    localparam logic [63:0] EG = 64'h9090_1111_0000_0001;
    localparam logic [63:0] EH = 64'h8080_1111_0000_0000;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic expect_beat(input string tag, input logic [63:0] d, input logic [7:0] k,
                               input logic l, input logic r);
        check({tag, "_val"},  64'(dst_if.val),  64'd1);
        check({tag, "_data"}, dst_if.data,      d);
        check({tag, "_keep"}, 64'(dst_if.keep), 64'(k));
        check({tag, "_last"}, 64'(dst_if.last), 64'(l));
        check({tag, "_srdy"}, 64'(src_if.rdy),  64'(r));
    endtask

    task automatic expect_idle(input string tag);
        check({tag, "_val"},  64'(dst_if.val),  64'd0);
        check({tag, "_last"}, 64'(dst_if.last), 64'd0);
        check({tag, "_srdy"}, 64'(src_if.rdy),  64'd1);
    endtask

    // Present a line at the negedge; it is accepted at the following posedge.
    task automatic offer(input logic [255:0] d, input logic [31:0] k, input logic l);
        @(negedge clk);
        src_if.val  = 1'b1;
        src_if.data = d;
        src_if.keep = k;
        src_if.last = l;
        #1;
        check("accept_no_comb_val", 64'(dst_if.val), 64'd0);
        check("accept_srdy",        64'(src_if.rdy), 64'd1);
    endtask

    task automatic next_cycle(input logic sval);
        @(negedge clk);
        src_if.val = sval;
        #1;
    endtask

    initial begin
        src_if.val  = 1'b0;
        src_if.data = '0;
        src_if.keep = '0;
        src_if.last = 1'b0;
        dst_if.rdy  = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        expect_idle("reset");

        // Single full last line.
        offer({EA, EB, EC, ED}, 32'hFFFF_FFFF, 1'b1);
        next_cycle(1'b0); expect_beat("full_a", EA, 8'hFF, 1'b0, 1'b0);
        next_cycle(1'b0); expect_beat("full_b", EB, 8'hFF, 1'b0, 1'b0);
        next_cycle(1'b0); expect_beat("full_c", EC, 8'hFF, 1'b0, 1'b0);
        next_cycle(1'b0); expect_beat("full_d", ED, 8'hFF, 1'b1, 1'b1);
        next_cycle(1'b0); expect_idle("full_done");

        // Truncated last line: two beats.
        offer({EA, EB, EC, ED}, {8'hFF, 8'h0F, 8'h00, 8'h00}, 1'b1);
        next_cycle(1'b0); expect_beat("trunc_a", EA, 8'hFF, 1'b0, 1'b0);
        next_cycle(1'b0); expect_beat("trunc_b", EB, 8'h0F, 1'b1, 1'b1);
        next_cycle(1'b0); expect_idle("trunc_done");

        // Back-to-back: non-last full line then last line with one element.
        offer({EA, EB, EC, ED}, {8'h00, 8'h00, 8'h00, 8'h00}, 1'b0);
        @(negedge clk);
        src_if.data = {EE, EF, EG, EH};
        src_if.keep = {8'hFF, 8'h00, 8'h00, 8'h00};
        src_if.last = 1'b1;
        #1;                expect_beat("b2b_1", EA, 8'h00, 1'b0, 1'b0);
        next_cycle(1'b1);  expect_beat("b2b_2", EB, 8'h00, 1'b0, 1'b0);
        next_cycle(1'b1);  expect_beat("b2b_3", EC, 8'h00, 1'b0, 1'b0);
        next_cycle(1'b1);  expect_beat("b2b_4", ED, 8'h00, 1'b0, 1'b1);
        next_cycle(1'b0);  expect_beat("b2b_5", EE, 8'hFF, 1'b1, 1'b1);
        next_cycle(1'b0);  expect_idle("b2b_done");

        // Backpressure on beat 2.
        offer({EA, EB, EC, ED}, 32'hFFFF_FFFF, 1'b1);
        next_cycle(1'b0); expect_beat("bp_a", EA, 8'hFF, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            dst_if.rdy = 1'b0;
            #1;
            expect_beat($sformatf("bp_hold%0d", i), EB, 8'hFF, 1'b0, 1'b0);
        end
        @(negedge clk);
        dst_if.rdy = 1'b1;
        #1;               expect_beat("bp_b", EB, 8'hFF, 1'b0, 1'b0);
        next_cycle(1'b0); expect_beat("bp_c", EC, 8'hFF, 1'b0, 1'b0);
        next_cycle(1'b0); expect_beat("bp_d", ED, 8'hFF, 1'b1, 1'b1);
        next_cycle(1'b0); expect_idle("bp_done");

        // Reset after the first beat discards the line.
        offer({EA, EB, EC, ED}, 32'hFFFF_FFFF, 1'b1);
        next_cycle(1'b0); expect_beat("rst_a", EA, 8'hFF, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        expect_idle("rst_mid");
        offer({EE, EF, EG, EH}, 32'hFFFF_FFFF, 1'b1);
        next_cycle(1'b0); expect_beat("rst_e", EE, 8'hFF, 1'b0, 1'b0);
        next_cycle(1'b0); expect_beat("rst_f", EF, 8'hFF, 1'b0, 1'b0);
        next_cycle(1'b0); expect_beat("rst_g", EG, 8'hFF, 1'b0, 1'b0);
        next_cycle(1'b0); expect_beat("rst_h", EH, 8'hFF, 1'b1, 1'b1);
        next_cycle(1'b0); expect_idle("rst_done");

        // Degenerate last line with no keep at all: only the top element.
        offer({EA, EB, EC, ED}, 32'h0000_0000, 1'b1);
        next_cycle(1'b0); expect_beat("empty_a", EA, 8'h00, 1'b1, 1'b1);
        next_cycle(1'b0); expect_idle("empty_done");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
